// File: rtl/spi_frame_master.sv
// Mode-0 MSB-first SPI master: one SSEL-low frame of FRAME_BYTES bytes per start; start is ignored (not queued) while busy.
// SSEL falls 1 clk after start and stays low 2*CLK_DIV+FRAME_BYTES*(16*CLK_DIV+1) clk. SPI_MASTER_AUTORUN_EN: enable acts as start.
module spi_frame_master #(
  parameter int CLK_DIV     = 4,
  parameter int FRAME_BYTES = 20,
  parameter int GAP_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [4:0] tx_addr,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  output logic [4:0] rx_addr,
  output logic [7:0] rx_data,
  input  logic       enable,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SSEL
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LO, S_HI, S_BEND, S_HOLD, S_GAP
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [4:0]  LAST_IDX = 5'(FRAME_BYTES - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_cnt;
  logic [4:0]  idx;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic        miso_q1;
  logic        miso_s;
  logic        go;

`ifdef SPI_MASTER_AUTORUN_EN
  assign go = start | enable;
`else
  logic unused_enable;
  assign unused_enable = enable;
  assign go = start;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_q1 <= 1'b0;
      miso_s  <= 1'b0;
    end else begin
      miso_q1 <= MISO;
      miso_s  <= miso_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      idx      <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_addr  <= '0;
      rx_valid <= 1'b0;
      rx_addr  <= '0;
      rx_data  <= '0;
      SCK      <= 1'b0;
      MOSI     <= 1'b0;
      SSEL     <= 1'b1;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            state   <= S_SETUP;
            busy    <= 1'b1;
            SSEL    <= 1'b0;
            tx_addr <= '0;
            idx     <= '0;
            cnt     <= '0;
          end
        end
        S_SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sh   <= tx_data;
            MOSI    <= tx_data[7];
            state   <= S_LO;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_LO: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            SCK   <= 1'b1;
            state <= S_HI;
            // Present the next byte's address early so a registered RAM has settled by BEND.
            if (bit_cnt == 3'd7) tx_addr <= idx + 5'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_HI: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            SCK     <= 1'b0;
            rx_sh   <= {rx_sh[6:0], miso_s};
            tx_sh   <= {tx_sh[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state    <= S_BEND;
              rx_valid <= 1'b1;
              rx_addr  <= idx;
              rx_data  <= {rx_sh[6:0], miso_s};
            end else begin
              state <= S_LO;
              MOSI  <= tx_sh[6];
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_BEND: begin
          idx     <= idx + 5'd1;
          cnt     <= '0;
          bit_cnt <= '0;
          if (idx == LAST_IDX) begin
            state <= S_HOLD;
          end else begin
            state <= S_LO;
            tx_sh <= tx_data;
            MOSI  <= tx_data[7];
          end
        end
        S_HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            SSEL    <= 1'b1;
            done    <= 1'b1;
            MOSI    <= 1'b0;
            tx_addr <= '0;
            state   <= S_GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed-sequence bench for spi_frame_master with random frame contents and a behavioural SPI slave/monitor.
module tb_spi_frame_master;

  localparam int CLK_DIV     = 4;
  localparam int FRAME_BYTES = 20;
  localparam int GAP_CYCLES  = 8;
  localparam int SSEL_LOW    = 2 * CLK_DIV + FRAME_BYTES * (16 * CLK_DIV + 1);
  localparam int PERIOD      = SSEL_LOW + GAP_CYCLES + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       enable = 1'b0;
  logic       busy, done, rx_valid;
  logic [4:0] tx_addr, rx_addr;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       SCK, MOSI, MISO, SSEL;

  logic [7:0] tx_mem [32];
  logic [7:0] miso_mem [32];
  int         miso_mode = 0;
  logic       slv_bit = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  // monitor state
  logic       prev_ssel = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0, mosi_at_rise = 1'b0;
  logic       chk_after = 1'b0;
  logic [7:0] cur = 8'h00;
  int         mon_bits = 0, s_bit = 0, s_byte = 0;
  int         sck_rises = 0, done_cnt = 0, fall_cnt = 0, viol = 0;
  int         hcnt = 0, lcnt = 0, last_high = 0, last_low = 0;
  logic [7:0] mosi_q [$];
  logic [4:0] rxa_q [$];
  logic [7:0] rxd_q [$];

  // per-frame bases
  int mb, rb, sr, d0, f0;

  always #5 clk = ~clk;

  always @(posedge clk) tx_data <= tx_mem[tx_addr];

  assign MISO = (miso_mode == 1) ? MOSI : (miso_mode == 2) ? 1'b1 : slv_bit;

  spi_frame_master #(
    .CLK_DIV(CLK_DIV), .FRAME_BYTES(FRAME_BYTES), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .tx_addr(tx_addr), .tx_data(tx_data), .rx_valid(rx_valid), .rx_addr(rx_addr),
    .rx_data(rx_data), .enable(enable), .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SSEL(SSEL)
  );

  // Bus monitor and mode-0 slave: sampled mid-cycle on the falling clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_ssel && !SSEL) begin
        fall_cnt++;
        last_high = hcnt;
        lcnt = 0; s_byte = 0; s_bit = 0; mon_bits = 0;
      end
      if (!prev_ssel && SSEL) begin
        last_low = lcnt;
        hcnt = 0;
      end
      if (SSEL !== prev_ssel && (SCK || prev_sck)) viol++;
      if (SSEL) hcnt++; else lcnt++;
      if (!prev_sck && SCK) begin
        sck_rises++;
        if (MOSI !== prev_mosi) viol++;
        mosi_at_rise = MOSI;
        chk_after = 1'b1;
        cur = {cur[6:0], MOSI};
        mon_bits++;
        if (mon_bits == 8) begin
          mosi_q.push_back(cur);
          mon_bits = 0;
        end
      end else if (chk_after) begin
        if (MOSI !== mosi_at_rise) viol++;
        chk_after = 1'b0;
      end
      if (prev_sck && !SCK && !SSEL) begin
        s_bit++;
        if (s_bit == 8) begin
          s_bit = 0;
          s_byte++;
        end
      end
      if (rx_valid) begin
        rxa_q.push_back(rx_addr);
        rxd_q.push_back(rx_data);
      end
      if (done) done_cnt++;
      prev_ssel = SSEL;
      prev_sck  = SCK;
      prev_mosi = MOSI;
      slv_bit   = miso_mem[s_byte[4:0]][3'(7 - s_bit)];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    mb = mosi_q.size();
    rb = rxa_q.size();
    sr = sck_rises;
    d0 = done_cnt;
    f0 = fall_cnt;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) begin
      tx_mem[i]   = 8'($urandom);
      miso_mem[i] = 8'($urandom);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt == d0 && k < 4000) begin
      tick();
      k++;
    end
    chk("done_seen", 32'(done_cnt - d0), 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    chk("gap_len", 32'(k), GAP_CYCLES);
    chk("tx_addr_idle", 32'(tx_addr), 0);
  endtask

  task automatic check_frame(input int mode);
    logic [7:0] e;
    chk("sck_rises", 32'(sck_rises - sr), 8 * FRAME_BYTES);
    chk("ssel_low_len", 32'(last_low), SSEL_LOW);
    chk("mosi_count", 32'(mosi_q.size() - mb), FRAME_BYTES);
    chk("rx_count", 32'(rxa_q.size() - rb), FRAME_BYTES);
    if (mosi_q.size() >= mb + FRAME_BYTES && rxa_q.size() >= rb + FRAME_BYTES) begin
      for (int i = 0; i < FRAME_BYTES; i++) begin
        e = (mode == 1) ? tx_mem[i] : (mode == 2) ? 8'hFF : miso_mem[i];
        chk("mosi_byte", 32'(mosi_q[mb + i]), 32'(tx_mem[i]));
        chk("rx_addr", 32'(rxa_q[rb + i]), i);
        chk("rx_data", 32'(rxd_q[rb + i]), 32'(e));
      end
    end
  endtask

  task automatic full_frame(input int mode);
    miso_mode = mode;
    snap();
    pulse_start();
    wait_done();
    wait_idle();
    check_frame(mode);
    chk("one_done", 32'(done_cnt - d0), 1);
  endtask

  initial begin
    int k;
    fill_random();
    for (int i = 0; i < 32; i++) tx_mem[i] = 8'(i * 8'h11);
    tick();
    tick();
    chk("rst_ssel", 32'(SSEL), 1);
    chk("rst_sck", 32'(SCK), 0);
    chk("rst_mosi", 32'(MOSI), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_tx_addr", 32'(tx_addr), 0);
    chk("rst_rx_addr", 32'(rx_addr), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    rst_n = 1'b1;
    tick();
    tick();

    // counting pattern out, random slave bytes in
    full_frame(0);

    // loopback and MISO tied high
    fill_random();
    full_frame(1);
    fill_random();
    full_frame(2);

    // start during byte 5 is dropped
    fill_random();
    miso_mode = 0;
    snap();
    pulse_start();
    k = 0;
    while (mosi_q.size() - mb < 5 && k < 2000) begin tick(); k++; end
    chk("reach_byte5", 32'(mosi_q.size() - mb), 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    wait_idle();
    check_frame(0);
    for (int i = 0; i < 30; i++) tick();
    chk("no_requeue_falls", 32'(fall_cnt - f0), 1);
    chk("no_requeue_busy", 32'(busy), 0);

    // start held high: next frame only after the gap
    fill_random();
    snap();
    start = 1'b1;
    wait_done();
    k = 0;
    while (fall_cnt < f0 + 2 && k < 100) begin tick(); k++; end
    start = 1'b0;
    chk("second_fall", 32'(fall_cnt - f0), 2);
    chk("held_gap", 32'(last_high), GAP_CYCLES + 1);
    mb = mosi_q.size(); rb = rxa_q.size(); sr = sck_rises; d0 = done_cnt;
    wait_done();
    wait_idle();
    check_frame(0);

    // asynchronous reset in byte 7 bit 3
    fill_random();
    snap();
    pulse_start();
    k = 0;
    while (!(mosi_q.size() - mb == 7 && mon_bits == 3 && !SCK) && k < 2000) begin tick(); k++; end
    chk("reach_b7_bit3", 32'(mosi_q.size() - mb), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ssel", 32'(SSEL), 1);
    chk("abort_sck", 32'(SCK), 0);
    chk("abort_busy", 32'(busy), 0);
    tick();
    tick();
    tick();
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    chk("abort_rx_count", 32'(rxa_q.size() - rb), 7);
    chk("abort_tx_addr", 32'(tx_addr), 0);
    rst_n = 1'b1;
    tick();
    fill_random();
    full_frame(0);

    // autorun enable
    snap();
    enable = 1'b1;
`ifdef SPI_MASTER_AUTORUN_EN
    k = 0;
    while (fall_cnt == f0 && k < 100) begin tick(); k++; end
    chk("autorun_first_fall", 32'(fall_cnt - f0), 1);
    k = 0;
    while (fall_cnt < f0 + 2 && k < 3000) begin tick(); k++; end
    chk("autorun_period", 32'(k), PERIOD);
    enable = 1'b0;
    d0 = done_cnt;
    wait_done();
    wait_idle();
`else
    for (int i = 0; i < 2 * PERIOD; i++) tick();
    chk("autorun_off_falls", 32'(fall_cnt - f0), 0);
    chk("autorun_off_busy", 32'(busy), 0);
    enable = 1'b0;
`endif

    chk("protocol_violations", 32'(viol), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
